// File: rtl/pcie_tx_arbiter.sv
// Two-source packet arbiter in front of the 64-bit PCIe AXIS TX port.
// Switches sources only at packet boundaries; a beat watchdog truncates runaway packets.
module pcie_tx_arbiter #(
    parameter int CPL_PRIO  = 0,
    parameter int MAX_BEATS = 72,
    parameter int CNT_W     = 16
) (
    input  logic             user_clk,
    input  logic             sys_rst_n,
    input  logic             user_lnk_up,
    input  logic [63:0]      cpl_tdata,
    input  logic [7:0]       cpl_tkeep,
    input  logic             cpl_tlast,
    input  logic             cpl_tvalid,
    output logic             cpl_tready,
    input  logic [63:0]      req_tdata,
    input  logic [7:0]       req_tkeep,
    input  logic             req_tlast,
    input  logic             req_tvalid,
    output logic             req_tready,
    output logic [63:0]      s_axis_tx_tdata,
    output logic [7:0]       s_axis_tx_tkeep,
    output logic             s_axis_tx_tlast,
    output logic             s_axis_tx_tvalid,
    input  logic             s_axis_tx_tready,
    output logic             tx_src_dsc,
    output logic             grant_cpl,
    output logic             grant_req,
    output logic [CNT_W-1:0] dsc_count
);

    // MAX_BEATS >= 3 keeps the watchdog compare reachable before the counter could wrap.
    localparam int              BC_W     = $clog2(MAX_BEATS + 1);
    localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GNT_CPL,
        GNT_REQ,
        DROP_CPL,
        DROP_REQ
    } state_t;

    state_t           state_q, state_d;
    logic             last_req_q, last_req_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] dsc_count_q, dsc_count_d;
    logic             grant_cpl_q, grant_req_q;

    logic        cpl_sel, req_sel, granted;
    logic [63:0] src_tdata;
    logic [7:0]  src_tkeep;
    logic        src_tlast, src_tvalid;
    logic        tx_tvalid, force_last, accept;
    logic        arb_cv, arb_rv;
    state_t      nxt_grant;

    function automatic state_t pick(input logic cv, input logic rv, input logic lr);
        state_t s;
        s = IDLE;
        if (CPL_PRIO != 0) begin
            if (cv)      s = GNT_CPL;
            else if (rv) s = GNT_REQ;
        end else begin
            if (cv && rv) s = lr ? GNT_CPL : GNT_REQ;
            else if (cv)  s = GNT_CPL;
            else if (rv)  s = GNT_REQ;
        end
        return s;
    endfunction

    always_comb begin
        cpl_sel = (state_q == GNT_CPL);
        req_sel = (state_q == GNT_REQ);
        granted = cpl_sel | req_sel;

        src_tdata  = req_sel ? req_tdata  : cpl_tdata;
        src_tkeep  = req_sel ? req_tkeep  : cpl_tkeep;
        src_tlast  = req_sel ? req_tlast  : cpl_tlast;
        src_tvalid = req_sel ? req_tvalid : cpl_tvalid;

        tx_tvalid  = user_lnk_up & granted & src_tvalid;
        force_last = (beat_cnt_q == LAST_CNT) & ~src_tlast;
        accept     = tx_tvalid & s_axis_tx_tready;

        s_axis_tx_tvalid = tx_tvalid;
        s_axis_tx_tdata  = granted ? src_tdata : '0;
        s_axis_tx_tkeep  = granted ? src_tkeep : '0;
        s_axis_tx_tlast  = tx_tvalid & (src_tlast | force_last);
        tx_src_dsc       = tx_tvalid & force_last;

        cpl_tready = user_lnk_up & ((cpl_sel & s_axis_tx_tready) | (state_q == DROP_CPL));
        req_tready = user_lnk_up & ((req_sel & s_axis_tx_tready) | (state_q == DROP_REQ));

        // On a tlast handshake the finishing source's tvalid belongs to the beat being
        // consumed, so it must not bid for the next packet.
        arb_cv    = cpl_tvalid & ~cpl_sel;
        arb_rv    = req_tvalid & ~req_sel;
        nxt_grant = pick(arb_cv, arb_rv, last_req_q);

        state_d     = state_q;
        last_req_d  = last_req_q;
        beat_cnt_d  = beat_cnt_q;
        dsc_count_d = dsc_count_q;

        case (state_q)
            IDLE: begin
                state_d = nxt_grant;
                if (nxt_grant != IDLE) last_req_d = (nxt_grant == GNT_REQ);
            end
            GNT_CPL, GNT_REQ: begin
                if (accept) begin
                    if (src_tlast) begin
                        state_d    = nxt_grant;
                        beat_cnt_d = '0;
                        if (nxt_grant != IDLE) last_req_d = (nxt_grant == GNT_REQ);
                    end else if (force_last) begin
                        state_d    = cpl_sel ? DROP_CPL : DROP_REQ;
                        beat_cnt_d = '0;
                        if (dsc_count_q != '1) dsc_count_d = dsc_count_q + 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DROP_CPL: if (cpl_tvalid && cpl_tlast) state_d = IDLE;
            DROP_REQ: if (req_tvalid && req_tlast) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Link loss abandons the packet; the core flushes its partial TLP.
        if (!user_lnk_up) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            last_req_d = last_req_q;
        end
    end

    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            last_req_q  <= 1'b1;
            beat_cnt_q  <= '0;
            dsc_count_q <= '0;
            grant_cpl_q <= 1'b0;
            grant_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_req_q  <= last_req_d;
            beat_cnt_q  <= beat_cnt_d;
            dsc_count_q <= dsc_count_d;
            grant_cpl_q <= (state_d == GNT_CPL);
            grant_req_q <= (state_d == GNT_REQ);
        end
    end

    assign grant_cpl = grant_cpl_q;
    assign grant_req = grant_req_q;
    assign dsc_count = dsc_count_q;

endmodule
